// File: rtl/fifo_byte_buffer.sv
// Byte-wide synchronous FIFO between the CRC stage and a downstream reader.
// One write and one read per cycle, registered read port, sticky overflow.
module fifo_byte_buffer #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          enable,
   input  logic [7:0]    fifo_data_con,
   input  logic          fifo_we,
   output logic          fifo_busy,
   input  logic          rd_en,
   output logic [7:0]    rd_data,
   output logic          rd_valid,
   output logic          empty,
   output logic          full,
   output logic [AW:0]   count,
   output logic          overflow
);

   localparam logic [AW:0] FULL_CNT   = (AW+1)'(DEPTH);
   localparam logic [AW:0] ALMOST_CNT = (AW+1)'(DEPTH - 1);

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wp_q, wp_d;
   logic [AW-1:0] rp_q, rp_d;
   logic [AW:0]   count_q, count_d;
   logic [7:0]    rd_data_q, rd_data_d;
   logic          rd_valid_q, rd_valid_d;
   logic          overflow_q, overflow_d;
   logic          wr_acc, rd_acc;

   assign empty     = (count_q == '0);
   assign full      = (count_q == FULL_CNT);
   assign count     = count_q;
   assign rd_data   = rd_data_q;
   assign rd_valid  = rd_valid_q;
   assign overflow  = overflow_q;
   // Busy anticipates the write that is about to take the last slot.
   assign fifo_busy = full | ((count_q == ALMOST_CNT) & fifo_we);

   // Full/empty are judged on pre-edge state, so a same-edge read never
   // frees room for a write and a same-edge write is never read through.
   always_comb begin
      wr_acc     = enable & fifo_we & ~full;
      rd_acc     = enable & rd_en & ~empty;
      wp_d       = wp_q;
      rp_d       = rp_q;
      count_d    = count_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      overflow_d = overflow_q;
      if (wr_acc)
         wp_d = wp_q + 1'b1;
      if (enable & fifo_we & full)
         overflow_d = 1'b1;
      if (rd_acc) begin
         rp_d       = rp_q + 1'b1;
         rd_data_d  = mem_q[rp_q];
         rd_valid_d = 1'b1;
      end
      case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wp_q       <= '0;
         rp_q       <= '0;
         count_q    <= '0;
         rd_data_q  <= 8'h00;
         rd_valid_q <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         wp_q       <= wp_d;
         rp_q       <= rp_d;
         count_q    <= count_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage is not cleared by reset; a write coinciding with reset is dropped.
   always_ff @(posedge clk) begin
      if (!reset && wr_acc)
         mem_q[wp_q] <= fifo_data_con;
   end

endmodule

// File: tb/tb_fifo_byte_buffer.sv
// Bench for fifo_byte_buffer: directed scenarios plus randomized traffic
// checked against a queue-based model of the FIFO behaviour.
module tb_fifo_byte_buffer;

   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          enable;
   logic [7:0]    fifo_data_con;
   logic          fifo_we;
   logic          fifo_busy;
   logic          rd_en;
   logic [7:0]    rd_data;
   logic          rd_valid;
   logic          empty;
   logic          full;
   logic [AW:0]   count;
   logic          overflow;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state
   logic [7:0] exp_q[$];
   logic       m_ovf;
   logic       m_rdv;
   logic [7:0] m_rdd;

   fifo_byte_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .fifo_data_con(fifo_data_con), .fifo_we(fifo_we), .fifo_busy(fifo_busy),
      .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
      .empty(empty), .full(full), .count(count), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic drive(input logic r, input logic en, input logic we,
                        input logic rd, input logic [7:0] d);
      reset         = r;
      enable        = en;
      fifo_we       = we;
      rd_en         = rd;
      fifo_data_con = we ? d : 8'hzz;
   endtask

   // Advance the model by the rules for one edge, then let the DUT take it.
   task automatic tick();
      int  sz;
      logic was_full, was_empty;
      sz        = exp_q.size();
      was_full  = (sz == DEPTH);
      was_empty = (sz == 0);
      if (reset) begin
         exp_q.delete();
         m_ovf = 1'b0;
         m_rdv = 1'b0;
         m_rdd = 8'h00;
      end else if (!enable) begin
         m_rdv = 1'b0;
      end else begin
         if (rd_en && !was_empty) begin
            m_rdd = exp_q.pop_front();
            m_rdv = 1'b1;
         end else begin
            m_rdv = 1'b0;
         end
         if (fifo_we) begin
            if (was_full) m_ovf = 1'b1;
            else          exp_q.push_back(fifo_data_con);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
      tick();
      tick();
      n_cmp++; if (empty !== 1'b1)     begin n_err++; $display("FAIL reset_empty got=%b exp=1", empty); end
      n_cmp++; if (full !== 1'b0)      begin n_err++; $display("FAIL reset_full got=%b exp=0", full); end
      n_cmp++; if (count !== 5'd0)     begin n_err++; $display("FAIL reset_count got=%0d exp=0", count); end
      n_cmp++; if (fifo_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", fifo_busy); end
      n_cmp++; if (rd_valid !== 1'b0)  begin n_err++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
      n_cmp++; if (rd_data !== 8'h00)  begin n_err++; $display("FAIL reset_rd_data got=%h exp=00", rd_data); end
      n_cmp++; if (overflow !== 1'b0)  begin n_err++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
      drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic test_basic();
      logic [7:0] vals [4];
      vals[0] = 8'hA5; vals[1] = 8'h3C; vals[2] = 8'h00; vals[3] = 8'hFF;
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b1, 1'b1, 1'b0, vals[i]);
         tick();
      end
      n_cmp++; if (count !== 5'd4) begin n_err++; $display("FAIL basic_count_filled got=%0d exp=4", count); end
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
         tick();
         n_cmp++; if (rd_valid !== 1'b1) begin n_err++; $display("FAIL basic_rd_valid[%0d] got=%b exp=1", i, rd_valid); end
         n_cmp++; if (rd_data !== vals[i]) begin n_err++; $display("FAIL basic_rd_data[%0d] got=%h exp=%h", i, rd_data, vals[i]); end
         n_cmp++; if (count !== 5'(3 - i)) begin n_err++; $display("FAIL basic_count[%0d] got=%0d exp=%0d", i, count, 3 - i); end
      end
      n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL basic_empty got=%b exp=1", empty); end
      tick();
      n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL basic_rd_empty_valid got=%b exp=0", rd_valid); end
      n_cmp++; if (rd_data !== 8'hFF) begin n_err++; $display("FAIL basic_rd_data_hold got=%h exp=ff", rd_data); end
      drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic test_fill_overflow();
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b0, 1'b1, 1'b1, 1'b0, 8'(i));
         tick();
      end
      drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      #1;
      n_cmp++; if (full !== 1'b1)      begin n_err++; $display("FAIL fill_full got=%b exp=1", full); end
      n_cmp++; if (count !== 5'd16)    begin n_err++; $display("FAIL fill_count got=%0d exp=16", count); end
      n_cmp++; if (fifo_busy !== 1'b1) begin n_err++; $display("FAIL fill_busy got=%b exp=1", fifo_busy); end
      n_cmp++; if (overflow !== 1'b0)  begin n_err++; $display("FAIL fill_no_overflow got=%b exp=0", overflow); end
      drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h55);
      tick();
      n_cmp++; if (overflow !== 1'b1)  begin n_err++; $display("FAIL ovf_set got=%b exp=1", overflow); end
      n_cmp++; if (count !== 5'd16)    begin n_err++; $display("FAIL ovf_count got=%0d exp=16", count); end
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
         tick();
         n_cmp++; if (rd_data !== 8'(i) || rd_valid !== 1'b1) begin
            n_err++; $display("FAIL fill_readback[%0d] got=%h/%b exp=%h/1", i, rd_data, rd_valid, 8'(i));
         end
      end
      n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL fill_drained_empty got=%b exp=1", empty); end
      drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic test_busy_edge();
      for (int i = 0; i < DEPTH - 1; i++) begin
         drive(1'b0, 1'b1, 1'b1, 1'b0, 8'($urandom_range(0, 255)));
         tick();
      end
      drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      #1;
      n_cmp++; if (count !== 5'd15)    begin n_err++; $display("FAIL busy_count15 got=%0d exp=15", count); end
      n_cmp++; if (fifo_busy !== 1'b0) begin n_err++; $display("FAIL busy_idle15 got=%b exp=0", fifo_busy); end
      drive(1'b0, 1'b1, 1'b1, 1'b0, 8'hC3);
      #1;
      n_cmp++; if (fifo_busy !== 1'b1) begin n_err++; $display("FAIL busy_same_cycle got=%b exp=1", fifo_busy); end
      tick();
      n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL busy_full_after got=%b exp=1", full); end
      while (exp_q.size() > 0) begin
         drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
         tick();
         n_cmp++; if (rd_data !== m_rdd || rd_valid !== 1'b1) begin
            n_err++; $display("FAIL busy_drain got=%h/%b exp=%h/1", rd_data, rd_valid, m_rdd);
         end
      end
      drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic test_simultaneous();
      drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h77);
      tick();
      n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL simul0_rd_valid got=%b exp=0", rd_valid); end
      n_cmp++; if (count !== 5'd1)    begin n_err++; $display("FAIL simul0_count got=%0d exp=1", count); end
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b1, 1'b1, 1'b0, 8'(8'h10 + i));
         tick();
      end
      drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h99);
      tick();
      n_cmp++; if (count !== 5'd5)    begin n_err++; $display("FAIL simul5_count got=%0d exp=5", count); end
      n_cmp++; if (rd_data !== 8'h77 || rd_valid !== 1'b1) begin
         n_err++; $display("FAIL simul5_oldest got=%h/%b exp=77/1", rd_data, rd_valid);
      end
      drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic test_wrap_random();
      int max_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         drive(1'b0, 1'b1, 1'b1, 1'b1, 8'($urandom_range(0, 255)));
         tick();
         if (int'(count) > max_cnt) max_cnt = int'(count);
         n_cmp++; if (rd_data !== m_rdd || rd_valid !== 1'b1 || count !== 5'(exp_q.size())) begin
            n_err++; $display("FAIL wrap_pair[%0d] got=%h/%b/%0d exp=%h/1/%0d", i, rd_data, rd_valid, count, m_rdd, exp_q.size());
         end
      end
      n_cmp++; if (max_cnt > DEPTH) begin n_err++; $display("FAIL wrap_max_count got=%0d exp<=16", max_cnt); end
      for (int i = 0; i < 300; i++) begin
         drive(1'b0, ($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
         #1;
         n_cmp++; if (fifo_busy !== ((exp_q.size() == DEPTH) || (exp_q.size() == DEPTH - 1 && fifo_we))) begin
            n_err++; $display("FAIL rand_busy[%0d] got=%b size=%0d we=%b", i, fifo_busy, exp_q.size(), fifo_we);
         end
         tick();
         n_cmp++; if (rd_data !== m_rdd || rd_valid !== m_rdv || count !== 5'(exp_q.size()) || overflow !== m_ovf) begin
            n_err++; $display("FAIL rand_state[%0d] got=%h/%b/%0d/%b exp=%h/%b/%0d/%b", i,
                              rd_data, rd_valid, count, overflow, m_rdd, m_rdv, exp_q.size(), m_ovf);
         end
      end
      drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic test_enable_reset();
      logic [7:0] held_data;
      logic       held_ovf;
      while (exp_q.size() > 0) begin
         drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
         tick();
      end
      for (int i = 0; i < 7; i++) begin
         drive(1'b0, 1'b1, 1'b1, 1'b0, 8'($urandom_range(0, 255)));
         tick();
      end
      held_data = m_rdd;
      held_ovf  = m_ovf;
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b0, 1'b1, 1'(i % 2 == 0), 8'hEE);
         tick();
         n_cmp++; if (count !== 5'd7 || rd_data !== held_data || overflow !== held_ovf || rd_valid !== 1'b0) begin
            n_err++; $display("FAIL enable_hold[%0d] got=%0d/%h/%b/%b exp=7/%h/%b/0", i,
                              count, rd_data, overflow, rd_valid, held_data, held_ovf);
         end
      end
      drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h42);
      tick();
      n_cmp++; if (empty !== 1'b1 || count !== 5'd0 || overflow !== 1'b0 || rd_valid !== 1'b0) begin
         n_err++; $display("FAIL midreset got=%b/%0d/%b/%b exp=1/0/0/0", empty, count, overflow, rd_valid);
      end
      drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
      tick();
      n_cmp++; if (rd_valid !== 1'b0 || count !== 5'd0) begin
         n_err++; $display("FAIL midreset_after got=%b/%0d exp=0/0", rd_valid, count);
      end
   endtask

   initial begin
      m_ovf = 1'b0;
      m_rdv = 1'b0;
      m_rdd = 8'h00;
      drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      test_reset();
      test_basic();
      test_fill_overflow();
      test_busy_edge();
      test_simultaneous();
      test_wrap_random();
      test_enable_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
